// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot/run/halt sequencing, prioritised next-PC select.
// Optional return-address stack is built when PC_GEN_RAS_EN is defined.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic            misalign,
    output logic            halted
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_INC   = XLEN'(INSTR_BYTES);

    function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |(addr & LOW_MASK);
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            fire;
    logic            ras_hit;
    logic [XLEN-1:0] ras_top;
    logic            ras_pop_take;
    logic            ras_push_take;

    assign fetch_valid = (state_q == ST_RUN) && !stall;
    assign fire        = fetch_valid && fetch_ready;
    assign fetch_pc    = pc_q;
    assign misalign    = misalign_q;
    assign halted      = (state_q == ST_HALT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misalign_d    = 1'b0;
        ras_pop_take  = 1'b0;
        ras_push_take = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                ras_push_take = ras_push;
                if (trap_valid) begin
                    pc_d       = align_down(trap_pc);
                    misalign_d = is_misaligned(trap_pc);
                end else if (redirect_valid) begin
                    pc_d       = align_down(redirect_pc);
                    misalign_d = is_misaligned(redirect_pc);
                end else begin
                    if (halt_req) state_d = ST_HALT;
                    // Stall freezes prediction and sequential advance, never trap/redirect.
                    if (!stall) begin
                        if (ras_pop && ras_hit) begin
                            ras_pop_take = 1'b1;
                            pc_d         = align_down(ras_top);
                            misalign_d   = is_misaligned(ras_top);
                        end else if (fire) begin
                            pc_d = pc_q + PC_INC;
                        end
                    end
                end
            end
            ST_HALT: begin
                if (trap_valid) begin
                    state_d    = ST_RUN;
                    pc_d       = align_down(trap_pc);
                    misalign_d = is_misaligned(trap_pc);
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_GEN_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]   sp_q, sp_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            ras_wr;
    logic [PW-1:0]   ras_wr_idx;

    assign ras_hit = (cnt_q != '0);
    assign ras_top = ras_mem_q[sp_q];

    // sp wraps naturally, so a push on a full stack overwrites the oldest entry.
    always_comb begin
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        ras_wr     = 1'b0;
        ras_wr_idx = sp_q;
        if (ras_pop_take && ras_push_take) begin
            ras_wr = 1'b1;
        end else if (ras_pop_take) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - (PW + 1)'(1);
        end else if (ras_push_take) begin
            sp_d       = sp_q + PW'(1);
            ras_wr     = 1'b1;
            ras_wr_idx = sp_q + PW'(1);
            if (cnt_q != (PW + 1)'(RAS_DEPTH)) cnt_d = cnt_q + (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_wr) ras_mem_q[ras_wr_idx] <= ras_push_addr;
    end
`else
    logic unused_ras;

    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = ^{ras_push, ras_push_addr, ras_pop_take, ras_push_take, RAS_DEPTH[0]};
`endif

endmodule
